deep_comb_case_driver: RTL and testbench

- Initiator side of the mode/op1/op2 -> output_val case-ALU interface.
- Accepts commands over a valid/ready handshake and drives registered operands into the combinational case-ALU.
- Captures the ALU result one cycle later and queues it in a small result FIFO.
- Delivers each result, tagged with its mode, over a second valid/ready handshake; keeps issue and default-path statistics.

---
 rtl/deep_comb_case_driver.sv | 135 +++++++++++++
 tb/tb_deep_comb_case_driver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/deep_comb_case_driver.sv
// Initiator for the mode/op1/op2 case-ALU: registers a command onto the ALU
// operands, captures the result a cycle later and queues it in a show-ahead FIFO.
module deep_comb_case_driver #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned MODE_W = 4,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [MODE_W-1:0] cmd_mode,
   input  logic [DATA_W-1:0] cmd_op1,
   input  logic [DATA_W-1:0] cmd_op2,
   output logic [MODE_W-1:0] alu_mode,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   input  logic [DATA_W-1:0] alu_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [MODE_W-1:0] res_mode,
   output logic [CNT_W-1:0]  issued_count,
   output logic [CNT_W-1:0]  dflt_count,
   output logic              busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t            state_q;
   logic [MODE_W-1:0] alu_mode_q;
   logic [DATA_W-1:0] alu_op1_q;
   logic [DATA_W-1:0] alu_op2_q;

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [MODE_W-1:0] mode_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic [AW:0]       count_d;

   logic [CNT_W-1:0]  issued_q;
   logic [CNT_W-1:0]  dflt_q;

   logic full;
   logic accept;
   logic push;
   logic pop;

   assign full      = (count_q == DEPTH_C);
   assign cmd_ready = (state_q == IDLE) && !full;
   assign accept    = cmd_valid && cmd_ready;
   // The DRIVE cycle always ends in a push; accept gating on !full keeps room for it.
   assign push      = (state_q == DRIVE);
   assign pop       = res_valid && res_ready;

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         alu_mode_q <= '0;
         alu_op1_q  <= '0;
         alu_op2_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  alu_mode_q <= cmd_mode;
                  alu_op1_q  <= cmd_op1;
                  alu_op2_q  <= cmd_op2;
                  state_q    <= DRIVE;
               end
            end
            DRIVE:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= '0;
            mode_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= alu_result;
            mode_q[wr_ptr_q] <= alu_mode_q;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_q <= '0;
         dflt_q   <= '0;
      end else if (push) begin
         if (issued_q != '1)
            issued_q <= issued_q + 1'b1;
         // Modes above 4 take the ALU's default XOR branch.
         if ((alu_mode_q > MODE_W'(4)) && (dflt_q != '1))
            dflt_q <= dflt_q + 1'b1;
      end
   end

   assign alu_mode     = alu_mode_q;
   assign alu_op1      = alu_op1_q;
   assign alu_op2      = alu_op2_q;
   assign res_valid    = (count_q != '0);
   assign res_data     = data_q[rd_ptr_q];
   assign res_mode     = mode_q[rd_ptr_q];
   assign issued_count = issued_q;
   assign dflt_count   = dflt_q;
   assign busy         = (state_q == DRIVE);

endmodule

// File: tb/tb_deep_comb_case_driver.sv
// Bench for deep_comb_case_driver: bench-side case-ALU, directed test-plan
// sequences, then random traffic checked against a queue-based model.
module tb_deep_comb_case_driver;

   localparam int DATA_W = 8;
   localparam int MODE_W = 4;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 5;
   localparam int MAXC   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [MODE_W-1:0] cmd_mode;
   logic [DATA_W-1:0] cmd_op1;
   logic [DATA_W-1:0] cmd_op2;
   logic [MODE_W-1:0] alu_mode;
   logic [DATA_W-1:0] alu_op1;
   logic [DATA_W-1:0] alu_op2;
   logic [DATA_W-1:0] alu_result;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic [MODE_W-1:0] res_mode;
   logic [CNT_W-1:0]  issued_count;
   logic [CNT_W-1:0]  dflt_count;
   logic              busy;

   deep_comb_case_driver #(
      .DATA_W(DATA_W), .MODE_W(MODE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
      .alu_mode(alu_mode), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_mode(res_mode),
      .issued_count(issued_count), .dflt_count(dflt_count), .busy(busy)
   );

   always #5 clk = ~clk;

   // Case-ALU stand-in; also used by the model to predict results.
   function automatic logic [7:0] alu_fn(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
      case (m)
         4'd0: return a & b;
         4'd1: case ({a[0], b[0]})
                  2'b00:   return a + b;
                  2'b01:   return a - b;
                  2'b10:   return a | b;
                  default: return ~b;
               endcase
         4'd2: if (a > b) begin
                  case (a[7:6])
                     2'b00:   return a - 8'd1;
                     2'b01:   return a - 8'd2;
                     default: return a - 8'd3;
                  endcase
               end else return b;
         4'd3: return a + b;
         4'd4: return a - b;
         default: return a ^ b;
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_mode, alu_op1, alu_op2);

   typedef struct packed {
      logic [3:0] m;
      logic [7:0] d;
   } ent_t;

   ent_t       q[$];
   logic       m_inflight;
   logic [3:0] m_mode;
   logic [7:0] m_op1;
   logic [7:0] m_op2;
   int         m_issued;
   int         m_dflt;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_inflight = 1'b0;
      m_mode = '0; m_op1 = '0; m_op2 = '0;
      m_issued = 0; m_dflt = 0;
   endtask

   task automatic compare_all(input string ph);
      check({ph, ".cmd_ready"}, 32'(cmd_ready), 32'(!m_inflight && q.size() < DEPTH));
      check({ph, ".busy"},      32'(busy),      32'(m_inflight));
      check({ph, ".res_valid"}, 32'(res_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check({ph, ".res_data"}, 32'(res_data), 32'(q[0].d));
         check({ph, ".res_mode"}, 32'(res_mode), 32'(q[0].m));
      end
      check({ph, ".alu_mode"},  32'(alu_mode),     32'(m_mode));
      check({ph, ".alu_op1"},   32'(alu_op1),      32'(m_op1));
      check({ph, ".alu_op2"},   32'(alu_op2),      32'(m_op2));
      check({ph, ".issued"},    32'(issued_count), 32'(m_issued));
      check({ph, ".dflt"},      32'(dflt_count),   32'(m_dflt));
   endtask

   // Called at a falling edge: check, drive, advance through one rising edge.
   task automatic cycle(input string ph, input logic v, input logic [3:0] m,
                        input logic [7:0] a, input logic [7:0] b, input logic rr);
      logic acc, psh, pp;
      ent_t e;
      compare_all(ph);
      cmd_valid = v; cmd_mode = m; cmd_op1 = a; cmd_op2 = b; res_ready = rr;
      acc = v && !m_inflight && (q.size() < DEPTH);
      psh = m_inflight;
      pp  = rr && (q.size() != 0);
      @(posedge clk);
      if (pp) void'(q.pop_front());
      if (psh) begin
         e.m = m_mode;
         e.d = alu_fn(m_mode, m_op1, m_op2);
         q.push_back(e);
         if (m_issued < MAXC) m_issued++;
         if (m_mode > 4 && m_dflt < MAXC) m_dflt++;
      end
      m_inflight = acc;
      if (acc) begin
         m_mode = m; m_op1 = a; m_op2 = b;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_mode = '0; cmd_op1 = '0; cmd_op2 = '0; res_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all("reset");
      rst = 1'b0;

      // Basic AND, nested case branches, default XOR and mode 4.
      cycle("basic",  1'b1, 4'd0, 8'hF0, 8'h3C, 1'b1);
      cycle("basic",  1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
      check("basic.res_data_0x30", 32'(res_data), 32'h30);
      cycle("nest1",  1'b1, 4'd1, 8'h03, 8'h01, 1'b1);
      cycle("nest1",  1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      check("nest1.res_data_0xFE", 32'(res_data), 32'hFE);
      cycle("nest2",  1'b1, 4'd2, 8'h50, 8'h10, 1'b1);
      cycle("nest2",  1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      check("nest2.res_data_0x4E", 32'(res_data), 32'h4E);
      cycle("dflt",   1'b1, 4'd9, 8'hAA, 8'h0F, 1'b1);
      cycle("dflt",   1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      check("dflt.res_data_0xA5", 32'(res_data), 32'hA5);
      check("dflt.count_1", 32'(dflt_count), 32'd1);
      cycle("mode4",  1'b1, 4'd4, 8'h20, 8'h05, 1'b1);
      cycle("mode4",  1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
      check("mode4.dflt_still_1", 32'(dflt_count), 32'd1);
      cycle("drain",  1'b0, 4'd0, 8'h00, 8'h00, 1'b1);

      // Fill to full under backpressure, then drain in order.
      for (int i = 0; i < 10; i++)
         cycle("fill", 1'b1, 4'(i + 3), 8'(8'h11 * i), 8'(8'h07 + i), 1'b0);
      check("fill.full_ready_low", 32'(cmd_ready), 32'd0);
      for (int i = 0; i < 6; i++)
         cycle("drainf", 1'b0, 4'd0, 8'h00, 8'h00, 1'b1);

      // Single entry held, then push and pop on the same edge.
      cycle("pp", 1'b1, 4'd3, 8'h12, 8'h34, 1'b0);
      cycle("pp", 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      cycle("pp", 1'b1, 4'd7, 8'h5A, 8'hFF, 1'b0);
      cycle("pp", 1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
      check("pp.one_entry_head", 32'(res_data), 32'h5A ^ 32'hFF);
      cycle("pp", 1'b0, 4'd0, 8'h00, 8'h00, 1'b1);

      // Two queued, one in DRIVE, then asynchronous reset.
      for (int i = 0; i < 5; i++)
         cycle("prerst", 1'b1, 4'(i), 8'(8'h40 + i), 8'(8'h21 + i), 1'b0);
      check("prerst.busy", 32'(busy), 32'd1);
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare_all("inrst");
      @(negedge clk);
      rst = 1'b0;
      cycle("postrst", 1'b1, 4'd0, 8'hF0, 8'h3C, 1'b1);
      cycle("postrst", 1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
      check("postrst.issued_1", 32'(issued_count), 32'd1);

      // Random traffic with alternating consumer pressure; saturates counters.
      for (int i = 0; i < 1500; i++) begin
         logic rr;
         rr = ((i / 100) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
         cycle("rand", $urandom_range(0, 3) != 0, 4'($urandom), 8'($urandom), 8'($urandom), rr);
      end
      compare_all("final");
      check("final.issued_sat", 32'(issued_count), 32'(MAXC));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
